// File: rtl/bus_slave_responder.sv
// bus_slave_responder: word-addressed register file target behind the bus initiator.
// Latency: a request accepted at edge N gives rsp_valid from after edge N; one transaction per 2 cycles at best.
// Backpressure: req_ready is low while a response is pending; the response is held until rsp_ready.
// Optional feature macro: BUS_SLAVE_ADDR_CHECK_EN. When defined, out-of-range addresses return rsp_err;
// when undefined, addresses wrap modulo DEPTH and rsp_err is tied low.
module bus_slave_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic [15:0]       o_wr_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic [15:0]         r_wr_count;

  logic                w_accept;
  logic                w_addr_ok;
  logic [IDX_W-1:0]    w_idx;
  logic                w_unused_addr;

  // Low address bits select the register; upper bits only matter to the range check.
  assign w_idx         = i_req_addr[IDX_W-1:0];
  assign w_unused_addr = ^i_req_addr;

`ifdef BUS_SLAVE_ADDR_CHECK_EN
  // Addresses at or beyond DEPTH are rejected rather than aliased.
  assign w_addr_ok = ({1'b0, i_req_addr} < (ADDR_W+1)'(DEPTH));
`else
  // Addresses alias modulo DEPTH, so every request is valid.
  assign w_addr_ok = 1'b1;
`endif

  assign w_accept   = i_req_valid && o_req_ready;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_err  = r_rsp_err;
  assign o_wr_count = r_wr_count;

  // State register; reset drops any pending response without a handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; ready is held low throughout reset.
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = !i_rst;
        if (w_accept) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Register file: cleared by reset, written only by accepted in-range writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_accept && i_req_write && w_addr_ok) begin
      r_mem[w_idx] <= i_req_data;
    end
  end

  // Response capture on accept plus the saturating write counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_wr_count <= '0;
    end else if (w_accept) begin
      r_rsp_data <= (!i_req_write && w_addr_ok) ? r_mem[w_idx] : '0;
`ifdef BUS_SLAVE_ADDR_CHECK_EN
      r_rsp_err  <= !w_addr_ok;
`else
      r_rsp_err  <= 1'b0;
`endif
      if (i_req_write && w_addr_ok && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_slave_responder.sv
// Directed bench for bus_slave_responder with a response scoreboard.
// Expected responses are queued when a request is accepted and popped at the response handshake.
// Builds with or without BUS_SLAVE_ADDR_CHECK_EN; the reference model follows the same macro.
module tb_bus_slave_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [15:0] wr_count;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_mem [16];
  int          m_wr;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          c0;

  bus_slave_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_wr = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("req_ready_in_reset", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    model_clear();
  endtask

  // Drive one request, wait for acceptance, queue its expected response.
  task automatic send(input logic wr, input logic [7:0] a, input logic [31:0] d);
    int   n;
    logic ok;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("req_accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
`ifdef BUS_SLAVE_ADDR_CHECK_EN
    ok = (a < 8'd16);
`else
    ok = 1'b1;
`endif
    e.err  = !ok;
    e.data = (!wr && ok) ? m_mem[a[3:0]] : 32'd0;
    if (wr && ok) begin
      m_mem[a[3:0]] = d;
      if (m_wr < 65535) m_wr++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Scramble request fields: they must have been sampled at the accept edge only.
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 8'($urandom); req_data = $urandom;
    check("rsp_valid_after_accept", {31'd0, rsp_valid}, 32'd1);
    check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
  endtask

  // Hold off the response for 'stall' cycles, then complete the handshake and score it.
  task automatic recv(input int stall);
    int   n;
    exp_t e;
    e = sb[0];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_data", rsp_data, e.data);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
      rsp_ready = 1'b0;
      return;
    end
    e = sb.pop_front();
    check("rsp_data", rsp_data, e.data);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
    check("rsp_valid_after_rsp", {31'd0, rsp_valid}, 32'd0);
    check("wr_count", {16'd0, wr_count}, 32'(m_wr));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
    model_clear();

    // Reset for two cycles, then inspect the idle state.
    do_reset();
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset_wr_count", {16'd0, wr_count}, 32'd0);

    // rsp_ready in IDLE must not disturb anything.
    rsp_ready = 1'b1;
    @(negedge clk);
    check("idle_rsp_ready_no_effect", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b0;

    // Write then read back.
    send(1'b1, 8'd1, 32'd2);
    recv(0);
    send(1'b0, 8'd1, 32'hFFFF_FFFF);
    recv(0);

    // Backpressure: response held 5 cycles while a second request waits.
    send(1'b0, 8'd1, 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd5; req_data = 32'h55;
    recv(5);
    send(1'b1, 8'd5, 32'h55);
    recv(0);
    send(1'b0, 8'd5, 32'd0);
    recv(0);

    // Back-to-back: 16 writes then 16 reads, 2 cycles per transaction.
    do_reset();
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 8'(i), 32'(i * 3));
      recv(0);
    end
    check("b2b_write_cycles", 32'(cyc - c0), 32'd32);
    check("b2b_wr_count", {16'd0, wr_count}, 32'd16);
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 8'(i), 32'd0);
      recv(0);
    end
    check("b2b_read_cycles", 32'(cyc - c0), 32'd32);

    // Out-of-range address: error with the check, alias to addr 4 without it.
    send(1'b1, 8'd20, 32'hDEAD);
    recv(0);
    send(1'b0, 8'd4, 32'd0);
    recv(0);

    // Reset while a response is pending drops it.
    send(1'b0, 8'd1, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_resp_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_in_resp_wr_count", {16'd0, wr_count}, 32'd0);
    check("rst_in_resp_req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    model_clear();
    send(1'b0, 8'd1, 32'd0);
    recv(0);

    // Saturation: preload the counter near the top, then keep writing.
    @(negedge clk);
    force dut.r_wr_count = 16'hFFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.r_wr_count;
    m_wr = 32'hFFFD;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(i + 2), 32'(i + 100));
      recv(0);
    end
    check("sat_wr_count", {16'd0, wr_count}, 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
